// File: rtl/lock_pkg.sv
// Shared types and constants for the coded-lock code manager.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    SET_NEW = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 4'b0101;

endpackage

// File: rtl/key_debounce.sv
// Turns a raw push-button level into a clean one-cycle pulse on the
// debounced rising edge: 2-flop synchronizer, stable-time filter, edge detect.
module key_debounce #(
  parameter int unsigned DB_TICKS = 240_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_prev;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_prev   <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      // Accept a new level only after it has differed for DB_TICKS cycles in a row.
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_TICKS - 1)) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_prev  <= r_stable;
      r_pulse <= r_stable & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/lock_code_writer.sv
// Passcode store, entry checker, failed-attempt counter and lockout timer.
// Define LOCK_DEBOUNCE_EN to accept raw button levels instead of clean pulses.
module lock_code_writer
  import lock_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE,
  parameter int unsigned       MAX_TRIES    = 3,
  parameter int unsigned       OPEN_TICKS   = 24_000_000,
  parameter int unsigned       LOCK_TICKS   = 120_000_000,
  parameter int unsigned       DB_TICKS     = 240_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           q,
  input  logic                           u,
  input  logic                           n,
  input  logic                           b,
  input  logic                           key_enter,
  input  logic                           key_set,
  output logic [CODE_W-1:0]              code_out,
  output logic                           led_open,
  output logic                           led_alarm,
  output logic                           led_set,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output state_t                         dbg_state
);

  localparam int          FW    = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMAX  = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
  localparam int          TW    = $clog2(TMAX + 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_TRIES);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TICKS - 1);

  logic              w_enter;
  logic              w_set;
  logic [CODE_W-1:0] w_word;
  logic [CODE_W-1:0] r_sw_meta;
  logic [CODE_W-1:0] r_sw_sync;

  state_t            r_state,  w_state_nxt;
  logic [CODE_W-1:0] r_code,   w_code_nxt;
  logic [FW-1:0]     r_fail,   w_fail_nxt;
  logic [TW-1:0]     r_timer,  w_timer_nxt;
  logic              r_led_alarm, w_alarm_nxt;
  logic              r_led_open;
  logic              r_led_set;

`ifdef LOCK_DEBOUNCE_EN
  key_debounce #(.DB_TICKS(DB_TICKS)) u_db_enter (
    .clk(clk), .rst(rst), .i_key(key_enter), .o_pulse(w_enter)
  );
  key_debounce #(.DB_TICKS(DB_TICKS)) u_db_set (
    .clk(clk), .rst(rst), .i_key(key_set), .o_pulse(w_set)
  );
`else
  assign w_enter = key_enter;
  assign w_set   = key_set;
`endif

  assign w_word = r_sw_sync;

  // Next-state logic; key_enter is tested first everywhere so it wins over key_set.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_fail_nxt  = r_fail;
    w_timer_nxt = r_timer;
    w_alarm_nxt = r_led_alarm;
    case (r_state)
      LOCKED: begin
        if (w_enter) begin
          if (w_word == r_code) begin
            w_state_nxt = OPEN;
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt  = r_fail + FW'(1);
            w_alarm_nxt = 1'b0;
            if (r_fail + FW'(1) == FAIL_MAX) w_state_nxt = LOCKOUT;
          end
        end
      end
      OPEN: begin
        if (w_enter)                  w_state_nxt = LOCKED;
        else if (w_set)               w_state_nxt = SET_NEW;
        else if (r_timer == OPEN_LAST) w_state_nxt = LOCKED;
        else                          w_timer_nxt = r_timer + TW'(1);
      end
      SET_NEW: begin
        if (w_enter) begin
          w_code_nxt  = w_word;
          w_state_nxt = LOCKED;
        end else if (w_set) begin
          w_state_nxt = OPEN;
        end
      end
      LOCKOUT: begin
        if (r_timer == LOCK_LAST) begin
          w_state_nxt = LOCKED;
          w_fail_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = LOCKED;
    endcase
    // Timers restart on state entry, except OPEN->SET_NEW which keeps the count.
    if (w_state_nxt != r_state && !(r_state == OPEN && w_state_nxt == SET_NEW))
      w_timer_nxt = '0;
    if (w_state_nxt == LOCKOUT)      w_alarm_nxt = 1'b0;
    else if (w_state_nxt != r_state) w_alarm_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
      r_state     <= LOCKED;
      r_code      <= DEFAULT_CODE;
      r_fail      <= '0;
      r_timer     <= '0;
      r_led_alarm <= 1'b1;
      r_led_open  <= 1'b1;
      r_led_set   <= 1'b1;
    end else begin
      r_sw_meta   <= {q, u, n, b};
      r_sw_sync   <= r_sw_meta;
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_fail      <= w_fail_nxt;
      r_timer     <= w_timer_nxt;
      r_led_alarm <= w_alarm_nxt;
      r_led_open  <= (w_state_nxt != OPEN);
      r_led_set   <= (w_state_nxt != SET_NEW);
    end
  end

  assign code_out  = r_code;
  assign led_open  = r_led_open;
  assign led_alarm = r_led_alarm;
  assign led_set   = r_led_set;
  assign fail_cnt  = r_fail;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lock_code_writer.sv
// Directed bench for lock_code_writer: expected snapshots are queued as each
// step is driven and compared once the registered outputs settle.
module tb_lock_code_writer;
  import lock_pkg::*;

  localparam int OPEN_T = 16;
  localparam int LOCK_T = 32;
  localparam int DB_T   = 8;
  localparam int W      = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       q = 1'b0, u = 1'b0, n = 1'b0, b = 1'b0;
  logic       key_enter = 1'b0;
  logic       key_set = 1'b0;
  logic [3:0] code_out;
  logic       led_open, led_alarm, led_set;
  logic [1:0] fail_cnt;
  state_t     dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int total = 0;
  int bad   = 0;

  lock_code_writer #(
    .DEFAULT_CODE(4'b0101), .MAX_TRIES(3), .OPEN_TICKS(OPEN_T),
    .LOCK_TICKS(LOCK_T), .DB_TICKS(DB_T)
  ) dut (
    .clk(clk), .rst(rst), .q(q), .u(u), .n(n), .b(b),
    .key_enter(key_enter), .key_set(key_set), .code_out(code_out),
    .led_open(led_open), .led_alarm(led_alarm), .led_set(led_set),
    .fail_cnt(fail_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign obs = {dbg_state, led_open, led_alarm, led_set, fail_cnt, code_out};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [3:0] w);
    {q, u, n, b} = w;
    repeat (2) tick();
  endtask

  task automatic pulse_enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic pulse_set();
    key_set = 1'b1;
    tick();
    key_set = 1'b0;
  endtask

  // scoreboard
  task automatic expect_snap(input state_t st, input logic lo, input logic la,
                             input logic ls, input logic [1:0] fc, input logic [3:0] cd);
    exp_q.push_back({st, lo, la, ls, fc, cd});
  endtask

  task automatic check(input string tag);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry queued, observed=%b", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b (state,open,alarm,set,fail,code)", tag, obs, e);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b0101);
    check("reset");
    rst = 1'b0;
    tick();

`ifdef LOCK_DEBOUNCE_EN
    // Five short bounces followed by a genuine hold: one wrong-code comparison only.
    set_word(4'b0000);
    for (int i = 0; i < 5; i++) begin
      key_enter = 1'b1; tick();
      key_enter = 1'b0; tick();
    end
    key_enter = 1'b1;
    repeat (DB_T + 6) tick();
    key_enter = 1'b0;
    repeat (DB_T + 6) tick();
    expect_snap(LOCKED, 1, 0, 1, 2'd1, 4'b0101);
    check("bounce_one_compare");

    key_enter = 1'b1; tick();
    key_enter = 1'b0;
    repeat (DB_T + 6) tick();
    expect_snap(LOCKED, 1, 0, 1, 2'd1, 4'b0101);
    check("glitch_rejected");

    set_word(4'b0101);
    key_enter = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == OPEN) break;
      tick();
    end
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b0101);
    check("debounced_open");
    key_enter = 1'b0;
    tick();
`else
    // correct default code opens, then auto-relocks after OPEN_T cycles
    set_word(4'b0101);
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b0101);
    pulse_enter(); check("open");
    repeat (OPEN_T - 1) tick();
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b0101);
    check("open_hold");
    tick();
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b0101);
    check("auto_relock");

    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b0101);
    pulse_enter(); check("open_manual");
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b0101);
    pulse_enter(); check("manual_relock");

    // program a new code
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b0101);
    pulse_enter(); check("open2");
    expect_snap(SET_NEW, 1, 1, 0, 2'd0, 4'b0101);
    pulse_set(); check("set_new");
    set_word(4'b1100);
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b1100);
    pulse_enter(); check("code_written");
    set_word(4'b0101);
    expect_snap(LOCKED, 1, 0, 1, 2'd1, 4'b1100);
    pulse_enter(); check("old_code_fails");
    set_word(4'b1100);
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b1100);
    pulse_enter(); check("new_code_opens");

    // abort from SET_NEW restarts the open timer
    expect_snap(SET_NEW, 1, 1, 0, 2'd0, 4'b1100);
    pulse_set(); check("set_new2");
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b1100);
    pulse_set(); check("abort");
    repeat (OPEN_T - 1) tick();
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b1100);
    check("abort_timer_restart");
    tick();
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b1100);
    check("abort_timeout");

    // three failures lead to lockout
    set_word(4'b0000);
    expect_snap(LOCKED, 1, 0, 1, 2'd1, 4'b1100);
    pulse_enter(); check("fail1");
    expect_snap(LOCKED, 1, 0, 1, 2'd2, 4'b1100);
    pulse_enter(); check("fail2");
    expect_snap(LOCKOUT, 1, 0, 1, 2'd3, 4'b1100);
    pulse_enter(); check("lockout");
    set_word(4'b1100);
    expect_snap(LOCKOUT, 1, 0, 1, 2'd3, 4'b1100);
    pulse_enter(); check("lockout_ignores");
    repeat (LOCK_T - 4) tick();
    expect_snap(LOCKOUT, 1, 0, 1, 2'd3, 4'b1100);
    check("lockout_hold");
    tick();
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b1100);
    check("lockout_end");

    // simultaneous enter+set in OPEN: enter wins
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b1100);
    pulse_enter(); check("open3");
    key_enter = 1'b1; key_set = 1'b1;
    tick();
    key_enter = 1'b0; key_set = 1'b0;
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b1100);
    check("enter_wins");
    tick();
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b1100);
    check("no_set_new");

    // asynchronous reset mid-cycle during SET_NEW
    expect_snap(OPEN, 0, 1, 1, 2'd0, 4'b1100);
    pulse_enter(); check("open4");
    expect_snap(SET_NEW, 1, 1, 0, 2'd0, 4'b1100);
    pulse_set(); check("set_new3");
    set_word(4'b1111);
    #2 rst = 1'b1;
    #1;
    expect_snap(LOCKED, 1, 1, 1, 2'd0, 4'b0101);
    check("async_reset");
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_code_writer.md
Name: lock_code_writer

Overview:
Sequential code-management end of the 4-switch coded lock. It holds the programmable 4-bit passcode, verifies entries made on the q/u/n/b switches, and lets the passcode be rewritten only after a successful unlock. It counts failed attempts and enforces a timed lockout. The stored code is exported so the combinational checker and any display logic compare against the same value.

Parameters:
DEFAULT_CODE, 4'b0101, passcode loaded at reset
MAX_TRIES, 3, consecutive failed entries that trigger lockout (1..15)
OPEN_TICKS, 24_000_000, clk cycles before auto-relock from OPEN (1 s at 24 MHz)
LOCK_TICKS, 120_000_000, clk cycles spent in LOCKOUT (5 s at 24 MHz)
DB_TICKS, 240_000, debounce stable-time in cycles (only used with DEBOUNCE_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
q, u, n, b  input  1 each  code switches; code word = {q,u,n,b}
key_enter  input  1  enter button, active-high, one-cycle pulse (level when DEBOUNCE_EN)
key_set  input  1  program button, active-high, one-cycle pulse (level when DEBOUNCE_EN)
code_out  output  4  currently stored passcode
led_open  output  1  active-low; 0 while in OPEN
led_alarm  output  1  active-low; 0 on failed entry and throughout LOCKOUT
led_set  output  1  active-low; 0 while in SET_NEW
fail_cnt  output  $clog2(MAX_TRIES+1)  consecutive failed entries

Behaviour:
- One clock; reset is asynchronous and active-high. All state is cleared on rst assertion, independent of clk.
- Reset values: state=LOCKED, code_out=DEFAULT_CODE, fail_cnt=0, led_open=1, led_alarm=1, led_set=1, all timers 0.
- Switch inputs pass through a 2-flop synchronizer. The comparison uses the synchronized word.
- Outputs are registered. All effects appear 1 cycle after the qualifying pulse.
- LOCKED:
  - key_enter with word==code_out: go to OPEN, clear fail_cnt, release the alarm.
  - key_enter with a mismatch: fail_cnt+1; led_alarm=0, held until the next key_enter or a state change.
  - If fail_cnt+1==MAX_TRIES: go to LOCKOUT instead.
  - key_set is ignored.
- OPEN:
  - Timer counts 0..OPEN_TICKS-1. At terminal count, go to LOCKED.
  - key_enter: relock to LOCKED immediately.
  - key_set: go to SET_NEW; the timer is not reset.
- SET_NEW:
  - key_enter: code_out<=word, then go to LOCKED.
  - key_set: abort to OPEN with code unchanged and the timer restarted.
  - No timeout.
- LOCKOUT:
  - led_alarm=0 for the whole state; all keys are ignored.
  - After LOCK_TICKS cycles, go to LOCKED with fail_cnt=0.
- Simultaneous key_enter and key_set in the same cycle: key_enter wins, key_set is dropped.
- Counter widths come from $clog2(param). Timers saturate-free: each clears on state entry.
- fail_cnt never exceeds MAX_TRIES.
- rst asserted mid-SET_NEW: code reverts to DEFAULT_CODE. Stored codes are not persistent across reset.

Optional Feature:
Macro LOCK_DEBOUNCE_EN.
- Defined: key_enter/key_set are raw active-high levels. Each passes a 2-flop synchronizer and a DB_TICKS stable-time debouncer, and a rising-edge detect generates the internal pulse. This adds DB_TICKS+3 cycles of latency.
- Undefined: inputs are taken as clean synchronous one-cycle pulses with no added latency, and DB_TICKS is unused.

Decomposition:
- Shared package lock_pkg holds:
  - the state enum {LOCKED, OPEN, SET_NEW, LOCKOUT} (2-bit);
  - the CODE_W=4 constant;
  - DEFAULT_CODE.
- One natural sub-module, key_debounce (synchronizer, debounce counter, edge pulse). It is instantiated twice, only under LOCK_DEBOUNCE_EN.

Test Plan:
1. Reset, then enter 0101: 1 cycle later led_open=0, fail_cnt=0. After OPEN_TICKS (bench override 16), led_open=1.
2. In OPEN press key_set, set word 1100, press key_enter: led_set pulses low, code_out=1100, state LOCKED. Entering 0101 then fails; entering 1100 opens.
3. Enter 0000 three times (MAX_TRIES=3): fail_cnt steps 1,2, then LOCKOUT. led_alarm=0 for LOCK_TICKS (override 32), and a correct entry in that window is ignored. Afterwards fail_cnt=0.
4. Same-cycle key_enter+key_set in OPEN: relock to LOCKED, SET_NEW not entered.
5. Assert rst asynchronously (mid-cycle) during SET_NEW after word 1111 is set: code_out=0101 and all LEDs=1 before the next clk edge.
6. With LOCK_DEBOUNCE_EN, bounce key_enter 5 times within DB_TICKS (override 8): exactly one comparison occurs.
